// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel window path.
//   PIX_W    : bits per grey pixel
//   WIN_TAPS : pixels in a 3x3 neighbourhood
//   WIN_W    : width of the packed window bus
//   win_idx  : element index of window row r (0 = newest) and column c (0 = newest)
package sobel_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_TAPS = 9;
  localparam int WIN_W    = PIX_W * WIN_TAPS;

  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return r * 3 + c;
  endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out stream bundle for sobel_window_gen.
//   i_pixel_data        : 8-bit pixel, raster order
//   i_pixel_data_valid  : pixel beat qualifier (no backpressure)
//   o_pixel_data        : packed 3x3 window, element i at [i*8 +: 8]
//   o_pixel_data_valid  : one-cycle strobe per emitted window
//   o_frame_done        : one-cycle strobe on the last beat of a frame
// master = pixel source / window sink, slave = window generator.
interface sobel_window_gen_if;
  import sobel_pkg::*;

  logic [PIX_W-1:0] i_pixel_data;
  logic             i_pixel_data_valid;
  logic [WIN_W-1:0] o_pixel_data;
  logic             o_pixel_data_valid;
  logic             o_frame_done;

  modport master (
    output i_pixel_data,
    output i_pixel_data_valid,
    input  o_pixel_data,
    input  o_pixel_data_valid,
    input  o_frame_done
  );

  modport slave (
    input  i_pixel_data,
    input  i_pixel_data_valid,
    output o_pixel_data,
    output o_pixel_data_valid,
    output o_frame_done
  );
endinterface

// File: rtl/sobel_line_delay.sv
// DEPTH-sample delay line built on a RAM with a single wrapping pointer.
// Read-before-write: o_data is the sample written DEPTH enables earlier.
// RAM contents are not reset; only the pointer is.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (pointer only)
//   i_en    : advance the line by one sample
//   i_data  : sample written at the current pointer
//   o_data  : sample currently stored at the pointer (oldest sample)
module sobel_line_delay #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q;
  logic [AW-1:0]    ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_en) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      mem_q[ptr_q] <= i_data;
    end
  end

  assign o_data = mem_q[ptr_q];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the sobel convolution stage.
// Accepts one pixel per valid beat in raster order and emits the packed
// 3x3 neighbourhood one cycle after each beat that completes a full-interior
// window (row >= 2 and col >= 2). No border padding.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (deasserted synchronously inside)
//   pix_if  : slave side of the pixel/window stream bundle
// Window packing: element r*3+c, r = 0 newest (bottom) row, c = 0 newest column.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sobel_window_gen_if.slave pix_if
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  // Reset: asserts asynchronously, releases two clocks after i_rst_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  logic beat;
  assign beat = pix_if.i_pixel_data_valid;

  // Line delays: tap[0] current pixel, tap[1] one row up, tap[2] two rows up.
  logic [2:0][PIX_W-1:0] tap;

  assign tap[0] = pix_if.i_pixel_data;

  sobel_line_delay #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W)
  ) u_line1 (
    .i_clk   (i_clk),
    .i_rst_n (rst_n_int),
    .i_en    (beat),
    .i_data  (tap[0]),
    .o_data  (tap[1])
  );

  sobel_line_delay #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W)
  ) u_line2 (
    .i_clk   (i_clk),
    .i_rst_n (rst_n_int),
    .i_en    (beat),
    .i_data  (tap[1]),
    .o_data  (tap[2])
  );

  // Position counters (pre-increment values describe the current beat).
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_col;
  logic          last_row;

  assign last_col = (col_q == LAST_COL);
  assign last_row = (row_q == LAST_ROW);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (beat) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Column shift registers, win[r][c]: c = 0 newest column.
  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;

  always_comb begin
    win_d = win_q;
    if (beat) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[r] = {win_q[r][1:0], tap[r]};
      end
    end
  end

  // The window register is loaded from the post-shift columns so the
  // completing beat's own pixel lands in element 0 with one cycle latency.
  logic [WIN_W-1:0] win_flat;

  always_comb begin
    win_flat = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        win_flat[win_idx(r, c)*PIX_W +: PIX_W] = win_d[r][c];
      end
    end
  end

  logic emit;
  assign emit = beat && (row_q >= RW'(2)) && (col_q >= CW'(2));

  logic [WIN_W-1:0] data_q;
  logic             valid_q;
  logic             done_q;

  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= emit;
      done_q  <= beat && last_col && last_row;
      if (emit) begin
        data_q <= win_flat;
      end
    end
  end

  assign pix_if.o_pixel_data       = data_q;
  assign pix_if.o_pixel_data_valid = valid_q;
  assign pix_if.o_frame_done       = done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int AW = 4;
  localparam int AH = 4;
  localparam int BW = 640;
  localparam int BH = 3;

  localparam logic [WIN_W-1:0] T1_FIRST = 72'h00_01_02_04_05_06_08_09_0A;
  localparam logic [WIN_W-1:0] T1_LAST  = 72'h05_06_07_09_0A_0B_0D_0E_0F;
  localparam logic [WIN_W-1:0] F2_FIRST = 72'h64_65_66_68_69_6A_6C_6D_6E;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [WIN_W-1:0] data;
    bit               fd;
    int               cyc;
  } exp_t;

  exp_t             q_a[$];
  exp_t             q_b[$];
  logic [WIN_W-1:0] got_a[$];
  int               got_b_n = 0;
  int               tests = 0;
  int               fails = 0;

  sobel_window_gen_if if_a ();
  sobel_window_gen_if if_b ();

  sobel_window_gen #(.IMG_WIDTH(AW), .IMG_HEIGHT(AH)) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .pix_if  (if_a)
  );

  sobel_window_gen #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH)) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .pix_if  (if_b)
  );

  task automatic check(input string name, input logic [WIN_W-1:0] act,
                       input logic [WIN_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Software model: frame store plus raster position, one per DUT.
  logic [7:0] img_a [AH][AW];
  logic [7:0] img_b [BH][BW];
  int ra = 0, ca = 0, rb = 0, cb = 0;

  task automatic beat_a(input logic [7:0] p);
    exp_t e;
    @(posedge clk); #1;
    if_a.i_pixel_data       = p;
    if_a.i_pixel_data_valid = 1'b1;
    img_a[ra][ca] = p;
    if (ra >= 2 && ca >= 2) begin
      e.data = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.data[(r*3+c)*8 +: 8] = img_a[ra-r][ca-c];
      e.fd  = (ra == AH-1) && (ca == AW-1);
      e.cyc = cyc + 1;
      q_a.push_back(e);
    end
    if (ca == AW-1) begin
      ca = 0;
      ra = (ra == AH-1) ? 0 : ra + 1;
    end else begin
      ca++;
    end
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if_a.i_pixel_data_valid = 1'b0;
      if_a.i_pixel_data       = 8'hEE;
    end
  endtask

  task automatic beat_b(input logic [7:0] p);
    exp_t e;
    @(posedge clk); #1;
    if_b.i_pixel_data       = p;
    if_b.i_pixel_data_valid = 1'b1;
    img_b[rb][cb] = p;
    if (rb >= 2 && cb >= 2) begin
      e.data = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.data[(r*3+c)*8 +: 8] = img_b[rb-r][cb-c];
      e.fd  = (rb == BH-1) && (cb == BW-1);
      e.cyc = cyc + 1;
      q_b.push_back(e);
    end
    if (cb == BW-1) begin
      cb = 0;
      rb = (rb == BH-1) ? 0 : rb + 1;
    end else begin
      cb++;
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents a window.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (if_a.o_pixel_data_valid === 1'b1) begin
      got_a.push_back(if_a.o_pixel_data);
      if (q_a.size() == 0) begin
        check("a_strobe_without_beat", WIN_W'(if_a.o_pixel_data_valid), '0);
      end else begin
        e = q_a.pop_front();
        check("a_window", if_a.o_pixel_data, e.data);
        check("a_cycle", WIN_W'(cyc), WIN_W'(e.cyc));
        check("a_frame_done", WIN_W'(if_a.o_frame_done), WIN_W'(e.fd));
      end
    end else if (rst_n === 1'b1) begin
      check("a_lone_frame_done", WIN_W'(if_a.o_frame_done), '0);
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (if_b.o_pixel_data_valid === 1'b1) begin
      got_b_n++;
      if (q_b.size() == 0) begin
        check("b_strobe_without_beat", WIN_W'(if_b.o_pixel_data_valid), '0);
      end else begin
        e = q_b.pop_front();
        check("b_window", if_b.o_pixel_data, e.data);
        check("b_cycle", WIN_W'(cyc), WIN_W'(e.cyc));
        check("b_frame_done", WIN_W'(if_b.o_frame_done), WIN_W'(e.fd));
      end
    end else if (rst_n === 1'b1 && if_b.o_frame_done !== 1'b0) begin
      check("b_lone_frame_done", WIN_W'(if_b.o_frame_done), '0);
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  if_a.o_pixel_data, '0);
    check({tag, "_valid"}, WIN_W'(if_a.o_pixel_data_valid), '0);
    check({tag, "_done"},  WIN_W'(if_a.o_frame_done), '0);
  endtask

  task automatic check_single_frame(input string tag);
    check({tag, "_count"}, WIN_W'(got_a.size()), WIN_W'(4));
    check({tag, "_first"}, (got_a.size() > 0) ? got_a[0] : '0, T1_FIRST);
    check({tag, "_last"},  (got_a.size() > 3) ? got_a[3] : '0, T1_LAST);
    check({tag, "_drain"}, WIN_W'(q_a.size()), '0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.i_pixel_data = '0;
    if_a.i_pixel_data_valid = 1'b0;
    if_b.i_pixel_data = '0;
    if_b.i_pixel_data_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    check("reset_b_valid", WIN_W'(if_b.o_pixel_data_valid), '0);
    check("reset_b_data", if_b.o_pixel_data, '0);
    rst_n = 1'b1;
    idle_a(3);

    // Test 1: continuous frame 0..15
    got_a.delete();
    for (int p = 0; p < 16; p++) beat_a(8'(p));
    idle_a(4);
    check_single_frame("t1");

    // Test 2: same frame with valid gaps
    got_a.delete();
    for (int p = 0; p < 16; p++) begin
      beat_a(8'(p));
      idle_a((p == 0) ? 2 : int'($urandom_range(0, 3)));
    end
    idle_a(4);
    check_single_frame("t2");

    // Test 3: two back-to-back frames
    got_a.delete();
    for (int p = 0; p < 16; p++) beat_a(8'(p));
    for (int p = 100; p < 116; p++) beat_a(8'(p));
    idle_a(4);
    check("t3_count", WIN_W'(got_a.size()), WIN_W'(8));
    check("t3_f2_first", (got_a.size() > 4) ? got_a[4] : '0, F2_FIRST);
    check("t3_drain", WIN_W'(q_a.size()), '0);

    // Test 4: reset after pixel 9, then a full frame
    for (int p = 0; p < 10; p++) beat_a(8'(p));
    idle_a(1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t4_rst_now");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs_zero("t4_rst_hold");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ra = 0;
    ca = 0;
    q_a.delete();
    idle_a(3);
    got_a.delete();
    for (int p = 0; p < 16; p++) beat_a(8'(p));
    idle_a(4);
    check_single_frame("t4");

    // Test 5: 640x3 random frame on the second instance
    got_b_n = 0;
    for (int i = 0; i < BW * BH; i++) beat_b(8'($urandom_range(0, 255)));
    @(posedge clk); #1;
    if_b.i_pixel_data_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t5_count", WIN_W'(got_b_n), WIN_W'(638));
    check("t5_drain", WIN_W'(q_b.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
